// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronised line, mid-bit sampling,
// valid/read handshake with frame-error and overrun flags.
module uart_rx #(
   parameter int CLK_DIV   = 5208,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk_50M,
   input  logic                 reset_n,
   input  logic                 uart_rxd,
   input  logic                 rx_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 rx_busy
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] LAST     = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   state_t               state;
   logic                 sync1;
   logic                 sync2;
   logic                 prev;
   logic                 fall;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;

   assign fall = prev & ~sync2;

   always_ff @(posedge clk_50M) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= uart_rxd;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (rx_read && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               if (fall) begin
                  state   <= START;
                  cnt     <= '0;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (sync2) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  shift <= {sync2, shift[DATA_BITS-1:1]};
                  if (bit_idx == LAST_BIT) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (sync2) begin
                     // a read in this same cycle loses to the new byte
                     rx_data  <= shift;
                     rx_valid <= 1'b1;
                     overrun  <= rx_valid & ~rx_read;
                     state    <= IDLE;
                     rx_busy  <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BRK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BRK: begin
               if (sync2) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx, plus directed
// boundary cases on a fast and a full-rate instance.
module tb_uart_rx;

   localparam int DIV = 16;
   localparam int BIG = 5208;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       reset_n, rxd, man_read, auto_read, rx_read;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, rx_busy;
   assign rx_read = man_read | auto_read;

   logic       big_reset_n, big_rxd, big_read;
   logic [7:0] big_rx_data;
   logic       big_rx_valid, big_frame_err, big_overrun, big_rx_busy;

   uart_rx #(.CLK_DIV(DIV), .DATA_BITS(8)) dut (
      .clk_50M(clk), .reset_n(reset_n), .uart_rxd(rxd),
      .rx_read(rx_read), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
   );

   uart_rx #(.CLK_DIV(BIG), .DATA_BITS(8)) dut_big (
      .clk_50M(clk), .reset_n(big_reset_n), .uart_rxd(big_rxd),
      .rx_read(big_read), .rx_data(big_rx_data),
      .rx_valid(big_rx_valid), .frame_err(big_frame_err),
      .overrun(big_overrun), .rx_busy(big_rx_busy)
   );

   typedef struct {
      bit         ferr;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   bit   auto_rd = 1'b1;
   bit   big_done = 1'b0;
   bit   big_ferr_seen = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(bit big, logic v);
      if (big) big_rxd = v;
      else rxd = v;
   endtask

   // start bit, data LSB first, stop bit; optional extra low time
   task automatic send(bit big, int div, logic [7:0] d,
                       logic stopb, int xlow);
      @(posedge clk);
      #1 drive(big, 1'b0);
      for (int k = 0; k < 8; k++) begin
         repeat (div) @(posedge clk);
         #1 drive(big, d[k]);
      end
      repeat (div) @(posedge clk);
      #1 drive(big, stopb);
      repeat (div + xlow) @(posedge clk);
      #1 drive(big, 1'b1);
   endtask

   task automatic pulse_read();
      @(posedge clk);
      #1 man_read = 1'b1;
      @(posedge clk);
      #1 man_read = 1'b0;
   endtask

   initial begin
      logic       pv;
      logic [7:0] pd;
      logic       pf;
      exp_t       e;
      pv = 1'b0;
      pd = 8'h00;
      pf = 1'b0;
      auto_read = 1'b0;
      forever begin
         @(negedge clk);
         auto_read = 1'b0;
         if (reset_n === 1'b1) begin
            if (frame_err) begin
               chk("ferr_width", {31'd0, pf}, 32'd0);
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_ferr: got 1 expected 0");
               end else begin
                  e = sb.pop_front();
                  chk("ferr_kind", {31'd0, e.ferr}, 32'd1);
               end
            end
            if (rx_valid && (!pv || rx_data !== pd)) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %0h expected none",
                           rx_data);
               end else begin
                  e = sb.pop_front();
                  chk("byte_kind", {31'd0, e.ferr}, 32'd0);
                  chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
               end
               if (auto_rd) auto_read = 1'b1;
            end
         end
         pv = rx_valid;
         pd = rx_data;
         pf = frame_err;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (big_frame_err === 1'b1) big_ferr_seen = 1'b1;
      end
   end

   initial begin
      int n;
      big_reset_n = 1'b0;
      big_rxd = 1'b1;
      big_read = 1'b0;
      repeat (5) @(posedge clk);
      #1 big_reset_n = 1'b1;
      repeat (5) @(posedge clk);
      @(posedge clk);
      #1 big_rxd = 1'b0;
      for (int i = 1; i <= 2620; i++) begin
         @(posedge clk);
         #1;
         if (i == 1000) big_rxd = 1'b1;
         if (i == 100) chk("glitch_busy_early", {31'd0, big_rx_busy}, 1);
         if (i == 2600) chk("glitch_busy_late", {31'd0, big_rx_busy}, 1);
      end
      chk("glitch_busy_idle", {31'd0, big_rx_busy}, 0);
      chk("glitch_no_valid", {31'd0, big_rx_valid}, 0);
      repeat (20) @(posedge clk);
      n = 0;
      fork
         send(1'b1, BIG, 8'hA5, 1'b1, 0);
         begin
            @(posedge clk);
            while (!big_rx_valid && n < 60000) begin
               @(posedge clk);
               #1;
               n++;
            end
         end
      join
      checks++;
      if (n < 49478 || n > 49479) begin
         errors++;
         $display("FAIL a5_latency: got %0d expected 49478..49479", n);
      end
      chk("a5_data", {24'd0, big_rx_data}, 32'hA5);
      chk("a5_valid", {31'd0, big_rx_valid}, 1);
      chk("a5_no_ferr", {31'd0, big_ferr_seen}, 0);
      chk("a5_no_overrun", {31'd0, big_overrun}, 0);
      big_done = 1'b1;
   end

   initial begin
      logic [7:0] d;
      bit         bad;
      int         gap;
      reset_n = 1'b0;
      rxd = 1'b1;
      man_read = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_data", {24'd0, rx_data}, 0);
      chk("rst_valid", {31'd0, rx_valid}, 0);
      chk("rst_ferr", {31'd0, frame_err}, 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
      chk("rst_busy", {31'd0, rx_busy}, 0);
      reset_n = 1'b1;
      repeat (10) @(posedge clk);

      sb.push_back('{ferr: 1'b1, data: 8'h3C});
      send(1'b0, DIV, 8'h3C, 1'b0, 40);
      chk("ferr_no_valid", {31'd0, rx_valid}, 0);
      repeat (5) @(posedge clk);
      sb.push_back('{ferr: 1'b0, data: 8'h81});
      send(1'b0, DIV, 8'h81, 1'b1, 0);
      repeat (20) @(posedge clk);

      for (int i = 0; i < 24; i++) begin
         d = 8'($urandom);
         bad = ($urandom_range(0, 5) == 0);
         sb.push_back('{ferr: bad, data: d});
         send(1'b0, DIV, d, !bad, bad ? int'($urandom_range(0, 30)) : 0);
         if (bad) gap = $urandom_range(3, 20);
         else if ($urandom_range(0, 3) == 0) gap = 0;
         else gap = $urandom_range(1, 30);
         repeat (gap) @(posedge clk);
      end
      repeat (40) @(posedge clk);

      auto_rd = 1'b0;
      sb.push_back('{ferr: 1'b0, data: 8'h11});
      sb.push_back('{ferr: 1'b0, data: 8'h22});
      send(1'b0, DIV, 8'h11, 1'b1, 0);
      send(1'b0, DIV, 8'h22, 1'b1, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("ovr_data", {24'd0, rx_data}, 32'h22);
      chk("ovr_valid", {31'd0, rx_valid}, 1);
      chk("ovr_flag", {31'd0, overrun}, 1);
      pulse_read();
      chk("ovr_read_valid", {31'd0, rx_valid}, 0);
      chk("ovr_read_flag", {31'd0, overrun}, 0);

      sb.push_back('{ferr: 1'b0, data: 8'h11});
      send(1'b0, DIV, 8'h11, 1'b1, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("pre_same_valid", {31'd0, rx_valid}, 1);
      sb.push_back('{ferr: 1'b0, data: 8'h55});
      fork
         send(1'b0, DIV, 8'h55, 1'b1, 0);
         begin
            @(posedge clk);
            repeat (154) @(posedge clk);
            #1 man_read = 1'b1;
            @(posedge clk);
            #1 man_read = 1'b0;
         end
      join
      chk("same_data", {24'd0, rx_data}, 32'h55);
      chk("same_valid", {31'd0, rx_valid}, 1);
      chk("same_overrun", {31'd0, overrun}, 0);
      pulse_read();
      chk("same_read_valid", {31'd0, rx_valid}, 0);
      auto_rd = 1'b1;
      repeat (10) @(posedge clk);

      fork
         send(1'b0, DIV, 8'hF0, 1'b1, 0);
         begin
            @(posedge clk);
            repeat (84) @(posedge clk);
            #1 reset_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 reset_n = 1'b1;
            chk("midrst_busy", {31'd0, rx_busy}, 0);
            chk("midrst_valid", {31'd0, rx_valid}, 0);
         end
      join
      repeat (10) @(posedge clk);
      sb.push_back('{ferr: 1'b0, data: 8'h0F});
      send(1'b0, DIV, 8'h0F, 1'b1, 0);
      repeat (100) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 0);

      while (!big_done) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
